sram_turn_arbiter: RTL and testbench



---
 rtl/sram_turn_arbiter_pkg.sv | 18 +
 rtl/sram_turn_arbiter_pick.sv | 85 ++++++++
 rtl/sram_turn_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sram_turn_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_turn_arbiter_pkg.sv
// Shared encodings for the SRAM turn arbiter: FSM states, requester ids and default SRAM bus widths.
package sram_turn_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } arb_state_t;

  localparam logic [1:0] RQ_VID = 2'd0;
  localparam logic [1:0] RQ_CPU = 2'd1;
  localparam logic [1:0] RQ_AUX = 2'd2;

  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 8;

endpackage

// File: rtl/sram_turn_arbiter_pick.sv
// Winner selection: video priority with burst limit, CPU/aux round-robin.
// The aux requester and its round-robin pointer exist only with SRAM_ARB_AUX_EN.
module sram_req_pick
  import sram_turn_arbiter_pkg::*;
#(
  parameter int MAX_VID_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pick_en,
  input  logic       vid_req,
  input  logic       cpu_req,
`ifdef SRAM_ARB_AUX_EN
  input  logic       aux_req,
`endif
  output logic       grant_valid,
  output logic [1:0] grant_id
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_VID_BURST);

  logic [3:0] burst_cnt_r;
  logic       nonvid_s;
  logic       force_nv_s;

`ifdef SRAM_ARB_AUX_EN
  logic aux_turn_r;
  assign nonvid_s = cpu_req | aux_req;
`else
  assign nonvid_s = cpu_req;
`endif

  // A full video burst yields exactly one slot to a waiting non-video requester.
  assign force_nv_s = (burst_cnt_r == BURST_MAX) && nonvid_s;

  // Combinational winner for the current IDLE cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = RQ_CPU;
    if (vid_req && !force_nv_s) begin
      grant_valid = 1'b1;
      grant_id    = RQ_VID;
    end else if (nonvid_s) begin
      grant_valid = 1'b1;
`ifdef SRAM_ARB_AUX_EN
      if (aux_req && (!cpu_req || aux_turn_r)) begin
        grant_id = RQ_AUX;
      end else begin
        grant_id = RQ_CPU;
      end
`else
      grant_id = RQ_CPU;
`endif
    end else begin
      grant_valid = 1'b0;
      grant_id    = RQ_CPU;
    end
  end

  // Burst counter and round-robin pointer advance only on IDLE decisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt_r <= 4'd0;
`ifdef SRAM_ARB_AUX_EN
      aux_turn_r  <= 1'b0;
`endif
    end else if (pick_en) begin
      if (grant_valid && (grant_id == RQ_VID)) begin
        burst_cnt_r <= (burst_cnt_r == BURST_MAX) ? burst_cnt_r : burst_cnt_r + 4'd1;
      end else begin
        burst_cnt_r <= 4'd0;
      end
`ifdef SRAM_ARB_AUX_EN
      if (grant_valid && (grant_id == RQ_CPU)) begin
        aux_turn_r <= 1'b1;
      end else if (grant_valid && (grant_id == RQ_AUX)) begin
        aux_turn_r <= 1'b0;
      end else begin
        aux_turn_r <= aux_turn_r;
      end
`endif
    end
  end

endmodule

// File: rtl/sram_turn_arbiter.sv
// Time-slot sequencer for the shared 512K x 8 SRAM (video, CPU, optional aux DMA).
// Define SRAM_ARB_AUX_EN to add the auxiliary requester port.
module sram_turn_arbiter
  import sram_turn_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1,
  parameter int MAX_VID_BURST = 4,
  parameter int AW            = SRAM_AW,
  parameter int DW            = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
`ifdef SRAM_ARB_AUX_EN
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_ack,
  output logic [DW-1:0] aux_rdata,
`endif
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_dout,
  output logic          sram_doe,
  input  logic [DW-1:0] sram_din,
  output logic          sram_we_n,
  output logic          busy
);

  localparam logic [1:0] LAST_STROBE = 2'(ACCESS_CYCLES - 1);

  arb_state_t    state_r, next_state_s;
  logic [1:0]    strobe_cnt_r;
  logic [1:0]    id_r;
  logic          we_r;
  logic          grant_valid_s;
  logic [1:0]    grant_id_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          we_s;
  logic          last_strobe_s;

  sram_req_pick #(.MAX_VID_BURST(MAX_VID_BURST)) u_pick (
    .clk         (clk),
    .rst_n       (rst_n),
    .pick_en     (state_r == ST_IDLE),
    .vid_req     (vid_req),
    .cpu_req     (cpu_req),
`ifdef SRAM_ARB_AUX_EN
    .aux_req     (aux_req),
`endif
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Access fields of whichever requester wins this IDLE cycle.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = vid_addr;
    sel_wdata_s = '0;
    case (grant_id_s)
      RQ_VID: begin
        sel_we_s    = 1'b0;
        sel_addr_s  = vid_addr;
        sel_wdata_s = '0;
      end
      RQ_CPU: begin
        sel_we_s    = cpu_we;
        sel_addr_s  = cpu_addr;
        sel_wdata_s = cpu_wdata;
      end
`ifdef SRAM_ARB_AUX_EN
      RQ_AUX: begin
        sel_we_s    = aux_we;
        sel_addr_s  = aux_addr;
        sel_wdata_s = aux_wdata;
      end
`endif
      default: begin
        sel_we_s    = 1'b0;
        sel_addr_s  = vid_addr;
        sel_wdata_s = '0;
      end
    endcase
  end

  assign last_strobe_s = (state_r == ST_STROBE) && (strobe_cnt_r == LAST_STROBE);
  assign we_s          = (state_r == ST_IDLE) ? sel_we_s : we_r;

  // Next-state logic of the access sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP:  next_state_s = ST_STROBE;
      ST_STROBE: begin
        if (last_strobe_s) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_STROBE;
        end
      end
      ST_HOLD:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every pin is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      strobe_cnt_r <= 2'd0;
      id_r         <= RQ_CPU;
      we_r         <= 1'b0;
      sram_a       <= '0;
      sram_dout    <= '0;
      sram_doe     <= 1'b0;
      sram_we_n    <= 1'b1;
      busy         <= 1'b0;
      vid_ack      <= 1'b0;
      cpu_ack      <= 1'b0;
      vid_rdata    <= '0;
      cpu_rdata    <= '0;
`ifdef SRAM_ARB_AUX_EN
      aux_ack      <= 1'b0;
      aux_rdata    <= '0;
`endif
    end else begin
      state_r      <= next_state_s;
      busy         <= (next_state_s != ST_IDLE);
      strobe_cnt_r <= ((state_r == ST_STROBE) && !last_strobe_s) ? strobe_cnt_r + 2'd1 : 2'd0;
      if ((state_r == ST_IDLE) && grant_valid_s) begin
        id_r      <= grant_id_s;
        we_r      <= sel_we_s;
        sram_a    <= sel_addr_s;
        sram_dout <= sel_wdata_s;
      end
      sram_doe  <= (next_state_s != ST_IDLE) && we_s;
      sram_we_n <= !((next_state_s == ST_STROBE) && we_s);
      vid_ack   <= (next_state_s == ST_HOLD) && (id_r == RQ_VID);
      cpu_ack   <= (next_state_s == ST_HOLD) && (id_r == RQ_CPU);
`ifdef SRAM_ARB_AUX_EN
      aux_ack   <= (next_state_s == ST_HOLD) && (id_r == RQ_AUX);
`endif
      if (last_strobe_s && !we_r) begin
        case (id_r)
          RQ_VID:  vid_rdata <= sram_din;
          RQ_CPU:  cpu_rdata <= sram_din;
`ifdef SRAM_ARB_AUX_EN
          RQ_AUX:  aux_rdata <= sram_din;
`endif
          default: cpu_rdata <= cpu_rdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_turn_arbiter.sv
// Directed self-checking bench for sram_turn_arbiter with a behavioural 512K x 8 SRAM model.
module tb_sram_turn_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;

  typedef struct {
    string         name;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          vid_req, vid_ack;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
`ifdef SRAM_ARB_AUX_EN
  logic          aux_req, aux_we, aux_ack;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata, aux_rdata;
`endif
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_dout, sram_din;
  logic          sram_doe, sram_we_n, busy;

  int n_vec  = 0;
  int n_fail = 0;

  sram_turn_arbiter #(.ACCESS_CYCLES(1), .MAX_VID_BURST(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
`ifdef SRAM_ARB_AUX_EN
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
`endif
    .sram_a(sram_a), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
    .sram_we_n(sram_we_n), .busy(busy)
  );

  // SRAM model: asynchronous read, write captured while we_n is low; preload port for setup.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  assign sram_din = mem[sram_a];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!sram_we_n) mem[sram_a] <= sram_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One CPU access; address/data are scrambled after the grant to prove they are latched.
  task automatic cpu_access(input vec_t v);
    int cyc, we_lo, doe_hi, lat;
    bit got;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    cyc = 0; we_lo = 0; doe_hi = 0; got = 1'b0; lat = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!sram_we_n) we_lo++;
      if (sram_doe) doe_hi++;
      if (cyc == 1) begin
        cpu_addr  = ~v.addr;
        cpu_wdata = ~v.wdata;
      end
      if (cpu_ack) begin
        got = 1'b1;
        lat = cyc;
        cpu_req = 1'b0;
        check({v.name, "_rdata"}, 32'(cpu_rdata), 32'(v.exp_rdata));
        check({v.name, "_addr"}, 32'(sram_a), 32'(v.addr));
      end
    end
    check({v.name, "_latency"}, 32'(lat), 32'd3);
    @(negedge clk);
    if (!sram_we_n) we_lo++;
    if (sram_doe) doe_hi++;
    check({v.name, "_we_n_low_clks"}, 32'(we_lo), v.we ? 32'd1 : 32'd0);
    check({v.name, "_doe_clks"}, 32'(doe_hi), v.we ? 32'd3 : 32'd0);
    check({v.name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    int n, cyc, acks;
    logic [DW-1:0] rd;
    logic [9:0] exp_cpu_turn;

    vecs[0] = '{"rd_12345", 1'b0, 19'h12345, 8'h00, 8'hA5};
    vecs[1] = '{"wr_00010", 1'b1, 19'h00010, 8'h3C, 8'hA5};
    vecs[2] = '{"rd_00010", 1'b0, 19'h00010, 8'h00, 8'h3C};
    vecs[3] = '{"wr_7ffff", 1'b1, 19'h7FFFF, 8'h5A, 8'h3C};
    vecs[4] = '{"rd_7ffff", 1'b0, 19'h7FFFF, 8'h00, 8'h5A};
    vecs[5] = '{"rd_00000", 1'b0, 19'h00000, 8'h00, 8'hC3};

    rst_n = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef SRAM_ARB_AUX_EN
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
`endif
    preload(19'h12345, 8'hA5);
    preload(19'h00000, 8'hC3);

    // Reset state
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_doe", 32'(sram_doe), 32'd0);
    check("rst_a", 32'(sram_a), 32'd0);
    check("rst_dout", 32'(sram_dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", {30'd0, vid_ack, cpu_ack}, 32'd0);
    check("rst_rdata", {16'd0, vid_rdata, cpu_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single CPU accesses
    for (int i = 0; i < 6; i++) cpu_access(vecs[i]);
    check("mem_00010", 32'(mem[19'h00010]), 32'h3C);
    check("mem_7ffff", 32'(mem[19'h7FFFF]), 32'h5A);

    // Video and CPU contending: burst limit forces one CPU slot every 5 grants
    exp_cpu_turn = 10'b10_0001_0000;
    repeat (2) @(negedge clk);
    vid_addr = 19'h12345; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 19'h00010; cpu_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (vid_ack && cpu_ack) check("dual_ack", 32'd1, 32'd0);
      if (vid_ack || cpu_ack) begin
        check($sformatf("grant%0d_is_cpu", n), 32'(cpu_ack), 32'(exp_cpu_turn[n]));
        if (vid_ack) check($sformatf("grant%0d_vid_rdata", n), 32'(vid_rdata), 32'hA5);
        if (cpu_ack) check($sformatf("grant%0d_cpu_rdata", n), 32'(cpu_rdata), 32'h3C);
        n++;
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    check("burst_grants", 32'(n), 32'd10);
    repeat (3) @(negedge clk);

`ifdef SRAM_ARB_AUX_EN
    // CPU and aux alternate, CPU first after reset
    do_reset();
    cpu_we = 1'b0; cpu_addr = 19'h00010; cpu_req = 1'b1;
    aux_we = 1'b0; aux_addr = 19'h00000; aux_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (aux_ack && cpu_ack) check("rr_dual_ack", 32'd1, 32'd0);
      if (aux_ack || cpu_ack) begin
        check($sformatf("rr%0d_is_aux", n), 32'(aux_ack), 32'(n % 2));
        if (aux_ack) check($sformatf("rr%0d_aux_rdata", n), 32'(aux_rdata), 32'hC3);
        n++;
      end
    end
    cpu_req = 1'b0; aux_req = 1'b0;
    check("rr_grants", 32'(n), 32'd4);
    repeat (3) @(negedge clk);
`endif

    // Reset during the strobe of a write aborts the access without an ack
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00100; cpu_wdata = 8'h77;
    @(negedge clk);
    check("abort_setup_doe", 32'(sram_doe), 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    check("abort_strobe_we_n", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_doe", 32'(sram_doe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    check("abort_ack2", 32'(cpu_ack), 32'd0);
    rst_n = 1'b1;
    v = '{"post_abort_rd", 1'b0, 19'h00010, 8'h00, 8'h3C};
    cpu_access(v);

    // Request dropped during SETUP still completes exactly once
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h12345;
    @(negedge clk);
    cpu_req = 1'b0;
    acks = 0; rd = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        acks++;
        rd = cpu_rdata;
      end
    end
    check("drop_ack_count", 32'(acks), 32'd1);
    check("drop_rdata", 32'(rd), 32'hA5);
    check("drop_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
